// File: rtl/button_event_gen.sv
// Two-channel button event generator: turns debounced, clock-synchronous
// button levels into single-cycle press / release / hold / auto-repeat events.

// One channel: edge detector, IDLE/PRESSED/HELD FSM, and a shared cycle counter.
module button_event_chan #(
  parameter int unsigned HOLD_CNT   = 1000,
  parameter int unsigned REPEAT_CNT = 250,
  parameter int unsigned CNT_W      = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic rep_en,
  output logic press,
  output logic rel,
  output logic hold,
  output logic rep,
  output logic held
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CNT - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prev_q;
  logic             press_d, rel_d, hold_d, rep_d;

  // State, counter, edge history and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
      press   <= 1'b0;
      rel     <= 1'b0;
      hold    <= 1'b0;
      rep     <= 1'b0;
      held    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= btn;
      press   <= press_d;
      rel     <= rel_d;
      hold    <= hold_d;
      rep     <= rep_d;
      held    <= (state_d == HELD);
    end
  end

  // Next-state, counter and pulse decisions for the current edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    hold_d  = 1'b0;
    rep_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn && !prev_q) begin
          press_d = 1'b1;
          cnt_d   = '0;
          state_d = PRESSED;
        end
      end
      PRESSED: begin
        if (!btn) begin
          rel_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == HOLD_LAST) begin
          hold_d  = 1'b1;
          cnt_d   = '0;
          state_d = HELD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn) begin
          rel_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (!rep_en) begin
          cnt_d = '0;
        end else if (cnt_q == REPEAT_LAST) begin
          rep_d = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// Top level: two fully independent channels sharing only clock, reset and rep_en.
module button_event_gen #(
  parameter int unsigned HOLD_CNT   = 1000,
  parameter int unsigned REPEAT_CNT = 250,
  parameter int unsigned CNT_W      = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn0,
  input  logic btn1,
  input  logic rep_en,
  output logic press0,
  output logic press1,
  output logic rel0,
  output logic rel1,
  output logic hold0,
  output logic hold1,
  output logic rep0,
  output logic rep1,
  output logic held0,
  output logic held1
);

  button_event_chan #(
    .HOLD_CNT  (HOLD_CNT),
    .REPEAT_CNT(REPEAT_CNT),
    .CNT_W     (CNT_W)
  ) u_chan0 (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn0),
    .rep_en(rep_en),
    .press (press0),
    .rel   (rel0),
    .hold  (hold0),
    .rep   (rep0),
    .held  (held0)
  );

  button_event_chan #(
    .HOLD_CNT  (HOLD_CNT),
    .REPEAT_CNT(REPEAT_CNT),
    .CNT_W     (CNT_W)
  ) u_chan1 (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn1),
    .rep_en(rep_en),
    .press (press1),
    .rel   (rel1),
    .hold  (hold1),
    .rep   (rep1),
    .held  (held1)
  );

endmodule

// File: tb/tb_button_event_gen.sv
// Self-checking bench for button_event_gen: directed scenarios followed by
// randomized button/rep_en/reset activity, against a timestamp-based model.
module tb_button_event_gen;

  localparam int HOLD = 8;
  localparam int REP  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn0 = 1'b0, btn1 = 1'b0, rep_en = 1'b1;
  logic press0, press1, rel0, rel1, hold0, hold1, rep0, rep1, held0, held1;

  int nvec = 0;
  int nerr = 0;
  int t = 0;

  // Model state: per channel, whether the button is logically down, whether the
  // long-press has been reached, the press edge time and the repeat anchor time.
  bit m_down [2];
  bit m_held [2];
  bit m_prev [2];
  int m_tp   [2];
  int m_anc  [2];

  button_event_gen #(
    .HOLD_CNT  (HOLD),
    .REPEAT_CNT(REP),
    .CNT_W     (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn0  (btn0),
    .btn1  (btn1),
    .rep_en(rep_en),
    .press0(press0),
    .press1(press1),
    .rel0  (rel0),
    .rel1  (rel1),
    .hold0 (hold0),
    .hold1 (hold1),
    .rep0  (rep0),
    .rep1  (rep1),
    .held0 (held0),
    .held1 (held1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s t=%0d got={p0,r0,h0,rp0,hd0,p1,r1,h1,rp1,hd1}=%b exp=%b",
               tag, t, got, exp);
    end
  endtask

  // Expected {press, rel, hold, rep, held} for channel c after this edge.
  task automatic model(input int c, input bit b, input bit re, input bit rs,
                       output logic [4:0] e);
    bit ep, er, eh, erp;
    ep = 0; er = 0; eh = 0; erp = 0;
    if (rs) begin
      m_down[c] = 0;
      m_held[c] = 0;
      m_prev[c] = 0;
    end else begin
      if (!m_down[c]) begin
        if (b && !m_prev[c]) begin
          ep = 1;
          m_down[c] = 1;
          m_tp[c] = t;
        end
      end else if (!b) begin
        er = 1;
        m_down[c] = 0;
        m_held[c] = 0;
      end else if (!m_held[c]) begin
        if (t - m_tp[c] == HOLD) begin
          eh = 1;
          m_held[c] = 1;
          m_anc[c] = t;
        end
      end else begin
        if (!re) m_anc[c] = t;
        else if (t - m_anc[c] == REP) begin
          erp = 1;
          m_anc[c] = t;
        end
      end
      m_prev[c] = b;
    end
    e = {ep, er, eh, erp, m_held[c]};
  endtask

  task automatic step(input string tag, input bit b0, input bit b1, input bit re, input bit rs);
    logic [4:0] e0, e1;
    btn0   = b0;
    btn1   = b1;
    rep_en = re;
    rst_n  = ~rs;
    @(posedge clk);
    t++;
    model(0, b0, re, rs, e0);
    model(1, b1, re, rs, e1);
    #1;
    chk(tag, {press0, rel0, hold0, rep0, held0, press1, rel1, hold1, rep1, held1}, {e0, e1});
  endtask

  initial begin
    int d0, d1;
    bit r0, r1, re;

    // Power-up reset, then reset held with both buttons already high.
    step("rst", 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step("rst_hi", 1, 1, 1, 1);
    step("press_after_rst", 1, 1, 1, 0);
    step("rel_both", 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) step("idle", 0, 0, 1, 0);

    // Short press: released before long-press.
    for (int i = 0; i < 5; i++) step("short", 1, 0, 1, 0);
    step("short_rel", 0, 0, 1, 0);
    step("idle", 0, 0, 1, 0);

    // Long press with auto-repeat.
    for (int i = 0; i <= 20; i++) step("long", 1, 0, 1, 0);
    step("long_rel", 0, 0, 1, 0);
    step("idle", 0, 0, 1, 0);

    // Auto-repeat suspended for a few edges while held.
    for (int i = 0; i <= 20; i++) step("rep_gap", 1, 0, !(i >= 10 && i <= 14), 0);
    step("rep_gap_rel", 0, 0, 1, 0);
    step("idle", 0, 0, 1, 0);

    // Both channels pressed together, channel 1 released earlier.
    for (int i = 0; i < 12; i++) step("dual", 1, (i < 9), 1, 0);
    step("dual_rel", 0, 0, 1, 0);
    step("idle", 0, 0, 1, 0);

    // Reset while held mid-repeat, button stays high through reset.
    for (int i = 0; i <= 10; i++) step("held_pre_rst", 1, 0, 1, 0);
    for (int i = 0; i < 2; i++) step("held_rst", 1, 0, 1, 1);
    for (int i = 0; i < 14; i++) step("post_rst", 1, 0, 1, 0);
    step("post_rst_rel", 0, 0, 1, 0);
    step("idle", 0, 0, 1, 0);

    // Randomized activity: level runs of random length, occasional rep_en
    // toggles and rare resets.
    r0 = 0; r1 = 0; re = 1;
    d0 = 1; d1 = 1;
    for (int i = 0; i < 4000; i++) begin
      d0--;
      d1--;
      if (d0 <= 0) begin
        r0 = ~r0;
        d0 = int'($urandom_range(1, 30));
      end
      if (d1 <= 0) begin
        r1 = ~r1;
        d1 = int'($urandom_range(1, 30));
      end
      if ($urandom_range(0, 15) == 0) re = ~re;
      step("rand", r0, r1, re, ($urandom_range(0, 399) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/button_event_gen.md
Name: button_event_gen

Overview:
- Consumer-side companion to the two-channel button debouncer.
- Takes the two debounced, clock-synchronous button levels and turns each into single-cycle events for downstream control FSMs:
  - press
  - release
  - long-press (hold)
  - auto-repeat while held
- Both channels are fully independent: identical per-channel FSM and counter, instantiated twice.

Parameters:
- HOLD_CNT, 1000: cycles a button must stay high after the press event before the hold pulse; legal range 1 .. 2^CNT_W-1.
- REPEAT_CNT, 250: cycles between auto-repeat pulses once in HELD; legal range 1 .. 2^CNT_W-1.
- CNT_W, 16: width of each per-channel cycle counter.

Ports:
- clk      in   1  system clock; all logic on rising edge.
- rst_n    in   1  synchronous active-low reset.
- btn0     in   1  debounced level, channel 0, active-high, already synchronous to clk.
- btn1     in   1  debounced level, channel 1, same as btn0.
- rep_en   in   1  auto-repeat enable, shared by both channels.
- press0   out  1  one-cycle pulse on channel 0 press.
- press1   out  1  one-cycle pulse on channel 1 press.
- rel0     out  1  one-cycle pulse on channel 0 release.
- rel1     out  1  one-cycle pulse on channel 1 release.
- hold0    out  1  one-cycle pulse when channel 0 reaches long-press.
- hold1    out  1  one-cycle pulse when channel 1 reaches long-press.
- rep0     out  1  one-cycle auto-repeat pulse, channel 0.
- rep1     out  1  one-cycle auto-repeat pulse, channel 1.
- held0    out  1  level, 1 while channel 0 is in HELD.
- held1    out  1  level, 1 while channel 1 is in HELD.

Behaviour:

Reset:
- Reset is synchronous and active-low: any rising clk edge with rst_n=0 is a reset edge.
- On a reset edge, per channel: state=IDLE, cnt=0, prev=0, and every output is 0.
- Reset takes priority over all other activity. A reset mid-press or mid-hold drops all state with no release pulse.
- prev resets to 0. A button already high when reset deasserts therefore produces a press on the first non-reset edge.

Output timing:
- All outputs are registered.
- Every pulse is high for exactly one cycle, in the cycle after the edge that decides it.

Per-channel FSM (IDLE, PRESSED, HELD), evaluated at each non-reset edge:
- prev <= btn on every edge.
- IDLE:
  - if btn=1 and prev=0 (this edge is E0): press<=1, cnt<=0, state<=PRESSED.
  - btn=1 with prev=1 in IDLE is impossible after reset and needs no handling beyond staying IDLE.
- PRESSED, btn=1:
  - if cnt==HOLD_CNT-1: hold<=1, cnt<=0, state<=HELD.
  - else: cnt<=cnt+1.
  - Result: hold pulse is decided at edge E0+HOLD_CNT.
- HELD, btn=1, rep_en=1:
  - if cnt==REPEAT_CNT-1: rep<=1, cnt<=0.
  - else: cnt<=cnt+1.
  - Result: first rep decided at E0+HOLD_CNT+REPEAT_CNT, then every REPEAT_CNT edges.
- HELD, btn=1, rep_en=0:
  - cnt<=0, no rep pulses.
  - When rep_en returns to 1, the count restarts from 0 and the next rep follows REPEAT_CNT edges later.
- PRESSED or HELD, btn=0:
  - rel<=1, cnt<=0, state<=IDLE.
  - No hold or rep is emitted on that edge, even if the counter would have hit its terminal value.

Pulse rules:
- held = (state==HELD): rises together with the hold pulse and falls together with the rel pulse.
- press, hold, rep and rel are mutually exclusive per channel in any cycle.
- A press and a release on the same channel are at least one cycle apart.
- Channels never interact: simultaneous events on both channels each produce their own pulses in the same cycle.

Counter:
- Counter width is CNT_W, unsigned.
- cnt never exceeds max(HOLD_CNT, REPEAT_CNT)-1, so no wrap-around is possible.
- HOLD_CNT=1 or REPEAT_CNT=1 is legal and yields a pulse on the first qualifying edge.

Test Plan (HOLD_CNT=8, REPEAT_CNT=4, CNT_W=8):
1. Reset, then hold rst_n=0 for 3 edges with btn0=btn1=1 -> all outputs 0 throughout reset; on first edge after release, press0=press1=1 for one cycle.
2. Raise btn0 at E0 for 5 cycles, then drop -> press0 after E0; rel0 after E5; no hold0, no rep0; held0 stays 0.
3. btn0 high 20 cycles with rep_en=1 ->
   - press0 after E0
   - hold0 after E8, with held0=1 from that cycle
   - rep0 after E12, E16, E20 (if still high)
   - on release: rel0, held0=0.
4. Same as 3, but rep_en=0 during E10..E14 -> no rep0 until E18 (restart at E14 + 4); hold0 unaffected.
5. btn0 and btn1 pressed on the same edge, btn1 released 3 cycles earlier -> press0 and press1 in the same cycle; rel1 then rel0 at their own edges; no cross-talk.
6. Reset asserted while btn0 in HELD with cnt=2 -> no rel0; all outputs 0; with btn0 still high, a fresh press0 on the first edge after reset, and the count restarts.
